// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if
// Groups the signals of one divided-clock measurement channel.
//   clk_div_in : divided clock under test (sampled as data)
//   start      : one-cycle request to open a measurement window
//   win_len    : window length in clk cycles, taken when start is accepted
//   busy       : window open
//   done       : one-cycle pulse, results valid
//   edge_cnt   : rising edges seen in the last window
//   high_cnt   : cycles sampled high in the last window
//   sat        : a counter saturated in the last window
// Modports: master drives the request side, slave is the monitor.
interface div_clk_monitor_if #(
    parameter int CW = 16
);
    logic          clk_div_in;
    logic          start;
    logic [CW-1:0] win_len;
    logic          busy;
    logic          done;
    logic [CW-1:0] edge_cnt;
    logic [CW-1:0] high_cnt;
    logic          sat;

    modport master (
        output clk_div_in, start, win_len,
        input  busy, done, edge_cnt, high_cnt, sat
    );

    modport slave (
        input  clk_div_in, start, win_len,
        output busy, done, edge_cnt, high_cnt, sat
    );
endinterface

// File: rtl/div_clk_monitor.sv
// div_clk_monitor
// Measures a divided clock (treated as data) over a window of win_len clk
// cycles: counts rising edges and high samples, with saturating counters.
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous, active-high reset
//   bus       : div_clk_monitor_if.slave (request, status and results)
//   dbg_state : current FSM state (0 IDLE, 1 MEASURE, 2 DONE)
// Build option: define DIV_CLK_MONITOR_SYNC_EN to put clk_div_in through a
// 2-flop synchronizer ahead of the sample register (2 extra cycles of
// sample latency). Without it the input is registered once. FSM timing is
// the same in both builds.
//
// Handshake: start is a one-cycle request, honoured only in IDLE and
// ignored otherwise (never queued). Once accepted, busy is high for exactly
// win_len cycles, then done pulses for one cycle with edge_cnt, high_cnt
// and sat already valid; those results hold until the next done pulse.
// win_len == 0 skips straight to the done pulse with zero results.
module div_clk_monitor #(
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    div_clk_monitor_if.slave     bus,
    output logic [1:0]           dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    logic          samp;
    logic          prev;
    logic [CW-1:0] remain;
    logic [CW-1:0] edge_acc;
    logic [CW-1:0] high_acc;
    logic          sat_acc;
    logic [CW-1:0] edge_nxt;
    logic [CW-1:0] high_nxt;
    logic          sat_nxt;

    assign dbg_state = state;

    // Sample history runs regardless of FSM state so that an edge on the
    // first window cycle is seen against the sample before it.
`ifdef DIV_CLK_MONITOR_SYNC_EN
    logic sync_a;
    logic sync_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            samp   <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= bus.clk_div_in;
            sync_b <= sync_a;
            samp   <= sync_b;
            prev   <= samp;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 1'b0;
            prev <= 1'b0;
        end else begin
            samp <= bus.clk_div_in;
            prev <= samp;
        end
    end
`endif

    // Next accumulator values for the current sample; a counter already at
    // its maximum stays there and flags saturation instead of wrapping.
    always_comb begin
        edge_nxt = edge_acc;
        high_nxt = high_acc;
        sat_nxt  = sat_acc;
        if (samp && !prev) begin
            if (edge_acc == CNT_MAX) sat_nxt  = 1'b1;
            else                     edge_nxt = edge_acc + 1'b1;
        end
        if (samp) begin
            if (high_acc == CNT_MAX) sat_nxt  = 1'b1;
            else                     high_nxt = high_acc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            remain       <= '0;
            edge_acc     <= '0;
            high_acc     <= '0;
            sat_acc      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.edge_cnt <= '0;
            bus.high_cnt <= '0;
            bus.sat      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        edge_acc <= '0;
                        high_acc <= '0;
                        sat_acc  <= 1'b0;
                        if (bus.win_len == '0) begin
                            state        <= DONE;
                            bus.done     <= 1'b1;
                            bus.edge_cnt <= '0;
                            bus.high_cnt <= '0;
                            bus.sat      <= 1'b0;
                        end else begin
                            state    <= MEASURE;
                            bus.busy <= 1'b1;
                            remain   <= bus.win_len;
                        end
                    end
                end
                MEASURE: begin
                    edge_acc <= edge_nxt;
                    high_acc <= high_nxt;
                    sat_acc  <= sat_nxt;
                    remain   <= remain - 1'b1;
                    // Last sample: publish results together with done so
                    // they are valid for the whole DONE cycle.
                    if (remain == CW'(1)) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.edge_cnt <= edge_nxt;
                        bus.high_cnt <= high_nxt;
                        bus.sat      <= sat_nxt;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_clk_monitor.sv
// tb_div_clk_monitor
// Drives two monitors (CW=16 and CW=4) with a shared divided-clock pattern
// and compares results with a sample-list model built from the recorded
// input history.
module tb_div_clk_monitor;
`ifdef DIV_CLK_MONITOR_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic [1:0] st16;
    logic [1:0] st4;

    div_clk_monitor_if #(.CW(16)) if16();
    div_clk_monitor_if #(.CW(4))  if4();

    assign if16.clk_div_in = din;
    assign if4.clk_div_in  = din;

    div_clk_monitor #(.CW(16)) u16 (.clk(clk), .rst(rst), .bus(if16), .dbg_state(st16));
    div_clk_monitor #(.CW(4))  u4  (.clk(clk), .rst(rst), .bus(if4),  .dbg_state(st4));

    // ---------------- clock / history ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    bit inp_h[0:8191];
    bit rst_h[0:8191];

    always @(posedge clk) begin
        inp_h[cyc] <= din;
        rst_h[cyc] <= rst;
        cyc        <= cyc + 1;
    end

    // Pattern driver: 0 low, 1 high, 2 period-3 (1 high, 2 low), 3 toggle, 4 random
    int pat = 0;
    always @(negedge clk) begin
        case (pat)
            0:       din = 1'b0;
            1:       din = 1'b1;
            2:       din = ((cyc % 3) == 0);
            3:       din = ((cyc % 2) == 0);
            default: din = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- scoreboard ----------------
    int vec  = 0;
    int errs = 0;

    task automatic check(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Sample seen by the monitor for input index j (zero if reset touched it
    // on its way through the input registers).
    function automatic int samp_at(input int j);
        if (j < 0) return 0;
        for (int t = j; t < j + LAT; t++)
            if (rst_h[t]) return 0;
        return int'(inp_h[j]);
    endfunction

    // Window accepted at edge s with n samples: sample k (1..n) is the input
    // captured LAT edges before measurement edge s+k.
    function automatic void model(input int s, input int n, input int cw,
                                  output int e, output int h, output int sv);
        int mx = (1 << cw) - 1;
        int re = 0;
        int rh = 0;
        for (int k = 1; k <= n; k++) begin
            int cur = samp_at(s + k - LAT);
            int prv = samp_at(s + k - LAT - 1);
            if (cur == 1 && prv == 0) re++;
            if (cur == 1) rh++;
        end
        e  = (re > mx) ? mx : re;
        h  = (rh > mx) ? mx : rh;
        sv = (re > mx || rh > mx) ? 1 : 0;
    endfunction

    function automatic int get_busy(input int sel);
        return sel != 0 ? int'(if4.busy) : int'(if16.busy);
    endfunction
    function automatic int get_done(input int sel);
        return sel != 0 ? int'(if4.done) : int'(if16.done);
    endfunction
    function automatic int get_edge(input int sel);
        return sel != 0 ? int'(if4.edge_cnt) : int'(if16.edge_cnt);
    endfunction
    function automatic int get_high(input int sel);
        return sel != 0 ? int'(if4.high_cnt) : int'(if16.high_cnt);
    endfunction
    function automatic int get_sat(input int sel);
        return sel != 0 ? int'(if4.sat) : int'(if16.sat);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_start(input int sel, input int n);
        if (sel != 0) begin
            if4.start   = 1'b1;
            if4.win_len = 4'(n);
        end else begin
            if16.start   = 1'b1;
            if16.win_len = 16'(n);
        end
    endtask

    task automatic clear_start();
        if4.start  = 1'b0;
        if16.start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Waits for done (bounded), checks busy length/done timing against the
    // window length, then results against the model and the given constants
    // (-1 = no constant), and that results hold after done.
    task automatic finish_window(input string tag, input int sel, input int s, input int n,
                                 input int exp_e, input int exp_h, input int exp_s,
                                 output int got_h);
        int busy_cyc = 0;
        int done_at  = -1;
        int me, mh, ms;
        for (int t = 0; t < n + 8 && done_at < 0; t++) begin
            if (get_done(sel) != 0) begin
                done_at = t;
                check({tag, "_busy_at_done"}, get_busy(sel), 0);
            end else begin
                if (get_busy(sel) != 0) busy_cyc++;
                @(negedge clk);
            end
        end
        got_h = get_high(sel);
        check({tag, "_done_at"}, done_at, n);
        check({tag, "_busy_cycles"}, busy_cyc, n);
        if (done_at >= 0) begin
            model(s, n, sel != 0 ? 4 : 16, me, mh, ms);
            check({tag, "_edge_model"}, get_edge(sel), me);
            check({tag, "_high_model"}, get_high(sel), mh);
            check({tag, "_sat_model"}, get_sat(sel), ms);
            if (exp_e >= 0) check({tag, "_edge_const"}, get_edge(sel), exp_e);
            if (exp_h >= 0) check({tag, "_high_const"}, get_high(sel), exp_h);
            if (exp_s >= 0) check({tag, "_sat_const"}, get_sat(sel), exp_s);
            @(negedge clk);
            @(negedge clk);
            check({tag, "_done_pulse"}, get_done(sel), 0);
            check({tag, "_edge_hold"}, get_edge(sel), me);
            check({tag, "_high_hold"}, get_high(sel), mh);
        end
    endtask

    task automatic run_window(input string tag, input int sel, input int p, input int n,
                              input int exp_e, input int exp_h, input int exp_s,
                              output int got_h);
        int s;
        pat = p;
        idle(LAT + 3);
        drive_start(sel, n);
        s = cyc;
        @(negedge clk);
        clear_start();
        finish_window(tag, sel, s, n, exp_e, exp_h, exp_s, got_h);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        string name;
        int    sel;
        int    p;
        int    n;
        int    exp_e;
        int    exp_h;
        int    exp_s;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int gh;
        int s;
        int dones;
        int done_t;

        tbl[0] = '{"div3_30",  0, 2, 30, 10, 10, 0};
        tbl[1] = '{"high_8",   0, 1, 8,  0,  8,  0};
        tbl[2] = '{"low_8",    0, 0, 8,  0,  0,  0};
        tbl[3] = '{"zero_len", 0, 2, 0,  0,  0,  0};
        tbl[4] = '{"tog_15",   1, 3, 15, -1, -1, 0};
        tbl[5] = '{"high_15",  1, 1, 15, 0,  15, 0};
        tbl[6] = '{"zero_c4",  1, 1, 0,  0,  0,  0};
        tbl[7] = '{"div3_1",   0, 2, 1,  -1, -1, 0};

        if16.start = 1'b0; if16.win_len = '0;
        if4.start  = 1'b0; if4.win_len  = '0;

        // reset state
        rst = 1'b1;
        idle(3);
        check("rst_busy16", int'(if16.busy), 0);
        check("rst_done16", int'(if16.done), 0);
        check("rst_edge16", int'(if16.edge_cnt), 0);
        check("rst_high16", int'(if16.high_cnt), 0);
        check("rst_sat16",  int'(if16.sat), 0);
        check("rst_busy4",  int'(if4.busy), 0);
        check("rst_high4",  int'(if4.high_cnt), 0);
        rst = 1'b0;
        idle(LAT + 3);

        // table vectors
        for (int i = 0; i < 8; i++) begin
            run_window(tbl[i].name, tbl[i].sel, tbl[i].p, tbl[i].n,
                       tbl[i].exp_e, tbl[i].exp_h, tbl[i].exp_s, gh);
            if (tbl[i].p == 3 && tbl[i].n == 15)
                check("tog_15_range", (gh >= 7 && gh <= 8) ? 1 : 0, 1);
        end

        // randomized windows
        for (int i = 0; i < 10; i++) begin
            int sel = $urandom_range(0, 1);
            int n   = sel != 0 ? $urandom_range(0, 15) : $urandom_range(0, 40);
            run_window("rand", sel, 4, n, -1, -1, -1, gh);
        end

        // reset in window cycle 5 of 20, with start asserted alongside rst
        pat = 2;
        idle(LAT + 3);
        drive_start(0, 20);
        @(negedge clk);
        clear_start();
        idle(4);
        rst = 1'b1;
        drive_start(0, 20);
        @(negedge clk);
        rst = 1'b0;
        clear_start();
        check("abort_busy", int'(if16.busy), 0);
        check("abort_edge", int'(if16.edge_cnt), 0);
        check("abort_high", int'(if16.high_cnt), 0);
        check("abort_sat",  int'(if16.sat), 0);
        dones = 0;
        for (int t = 0; t < 25; t++) begin
            if (if16.done || if16.busy) dones++;
            @(negedge clk);
        end
        check("abort_no_done_or_busy", dones, 0);
        run_window("after_abort", 0, 2, 30, 10, 10, 0, gh);

        // start re-pulsed mid-window is ignored
        pat = 4;
        idle(LAT + 3);
        drive_start(0, 12);
        s = cyc;
        @(negedge clk);
        clear_start();
        idle(3);
        drive_start(0, 3);
        @(negedge clk);
        clear_start();
        if16.win_len = 16'd12;
        dones  = 0;
        done_t = -1;
        for (int t = 0; t < 25; t++) begin
            if (if16.done) begin
                dones++;
                if (done_t < 0) done_t = cyc - s;
                if (dones == 1) begin
                    int me, mh, ms;
                    model(s, 12, 16, me, mh, ms);
                    check("repulse_edge", int'(if16.edge_cnt), me);
                    check("repulse_high", int'(if16.high_cnt), mh);
                end
            end
            @(negedge clk);
        end
        check("repulse_done_count", dones, 1);
        check("repulse_done_time", done_t, 13);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    // overall time bound
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
